// File: rtl/cpu_mult_pkg.sv
// cpu_mult_pkg: shared mode encoding and chunking constants for the pipelined multiplier
package cpu_mult_pkg;
  typedef enum logic [1:0] {MUL = 2'd0, MULXSS = 2'd1, MULXUU = 2'd2, MULXSU = 2'd3} mode_e;
  localparam int CHUNK_W = 16;
  function automatic int chunk_cnt(input int w);
    return w / CHUNK_W;
  endfunction
endpackage

// File: rtl/cpu_mult_pipe_if.sv
// cpu_mult_pipe_if: operand/result handshake bundle plus flush.
// master drives flush, in_valid, in_mode, in_src1/2, out_ready; slave drives in_ready, out_valid, out_result.
// Tags (in_tag/out_tag, TAG_W) exist only with CPU_MULT_PIPE_TAG_EN.
interface cpu_mult_pipe_if #(
  parameter int DATA_W = 32
`ifdef CPU_MULT_PIPE_TAG_EN
  , parameter int TAG_W = 5
`endif
);
  import cpu_mult_pkg::*;
  logic flush;
  logic in_valid;
  logic in_ready;
  mode_e in_mode;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_result;
`ifdef CPU_MULT_PIPE_TAG_EN
  logic [TAG_W-1:0] in_tag;
  logic [TAG_W-1:0] out_tag;
  modport master(output flush, in_valid, in_mode, in_src1, in_src2, in_tag, out_ready,
                 input in_ready, out_valid, out_result, out_tag);
  modport slave(input flush, in_valid, in_mode, in_src1, in_src2, in_tag, out_ready,
                output in_ready, out_valid, out_result, out_tag);
`else
  modport master(output flush, in_valid, in_mode, in_src1, in_src2, out_ready,
                 input in_ready, out_valid, out_result);
  modport slave(input flush, in_valid, in_mode, in_src1, in_src2, out_ready,
                output in_ready, out_valid, out_result);
`endif
endinterface

// File: rtl/cpu_mult_pipe_cell.sv
// cpu_mult_pipe_cell: one registered 17x17 signed multiply with load enable.
// Ports: clk, en (load), a/b signed 17-bit operands, p signed 34-bit registered product.
module cpu_mult_pipe_cell (
  input  logic               clk,
  input  logic               en,
  input  logic signed [16:0] a,
  input  logic signed [16:0] b,
  output logic signed [33:0] p
);
  always_ff @(posedge clk)
    if (en) p <= a * b;
endmodule

// File: rtl/cpu_mult_pipe.sv
// cpu_mult_pipe: three-stage valid/ready pipelined multiplier (MUL/MULXSS/MULXUU/MULXSU).
// Ports: clk, reset (sync, active-high), bus (cpu_mult_pipe_if.slave: flush, in_*, out_*).
// Optional: CPU_MULT_PIPE_TAG_EN carries in_tag through to out_tag.
module cpu_mult_pipe
  import cpu_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input logic clk,
  input logic reset,
  cpu_mult_pipe_if.slave bus
);
  localparam int N  = chunk_cnt(DATA_W);
  localparam int PW = 2 * DATA_W;
  if (DATA_W % CHUNK_W != 0 || DATA_W < 16 || DATA_W > 64 || TAG_W < 1) begin : g_bad_param
    $error("cpu_mult_pipe: DATA_W must be a multiple of 16 in 16..64 and TAG_W >= 1");
  end
  logic s1_valid, s2_valid, s1_hi, s2_hi;
  logic s1_en, s2_en, s3_en, in_xfer;
  logic signed [DATA_W:0] s1_a, s1_b;
  logic signed [CHUNK_W:0] a_ch [N];
  logic signed [CHUNK_W:0] b_ch [N];
  logic signed [2*CHUNK_W+1:0] pp [N][N];
  logic [PW-1:0] sum;
  // a stage may load when it is empty or its content moves on this cycle
  assign s3_en = !bus.out_valid || bus.out_ready;
  assign s2_en = !s2_valid || s3_en;
  assign s1_en = !s1_valid || s2_en;
  assign bus.in_ready = s1_en && !bus.flush;
  assign in_xfer = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk) begin
    if (reset || bus.flush) s1_valid <= 1'b0;
    else if (s1_en) s1_valid <= in_xfer;
    if (in_xfer) begin
      s1_a  <= {(bus.in_mode == MULXSS || bus.in_mode == MULXSU) && bus.in_src1[DATA_W-1], bus.in_src1};
      s1_b  <= {(bus.in_mode == MULXSS) && bus.in_src2[DATA_W-1], bus.in_src2};
      s1_hi <= bus.in_mode != MUL;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || bus.flush) s2_valid <= 1'b0;
    else if (s2_en) s2_valid <= s1_valid;
    if (s1_valid && s2_en) s2_hi <= s1_hi;
  end
  // only the top chunk carries the sign bit of the extended operand
  for (genvar i = 0; i < N; i++) begin : g_ch
    if (i == N - 1) begin : g_top
      assign a_ch[i] = s1_a[DATA_W -: CHUNK_W+1];
      assign b_ch[i] = s1_b[DATA_W -: CHUNK_W+1];
    end else begin : g_low
      assign a_ch[i] = {1'b0, s1_a[i*CHUNK_W +: CHUNK_W]};
      assign b_ch[i] = {1'b0, s1_b[i*CHUNK_W +: CHUNK_W]};
    end
    for (genvar j = 0; j < N; j++) begin : g_pp
      cpu_mult_pipe_cell u_cell (.clk(clk), .en(s1_valid && s2_en), .a(a_ch[i]), .b(b_ch[j]), .p(pp[i][j]));
    end
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        sum = sum + (PW'(pp[i][j]) << (CHUNK_W * (i + j)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
    end else begin
      if (bus.flush) bus.out_valid <= 1'b0;
      else if (s3_en) bus.out_valid <= s2_valid;
      if (s2_valid && s3_en) bus.out_result <= s2_hi ? sum[PW-1:DATA_W] : sum[DATA_W-1:0];
    end
  end
`ifdef CPU_MULT_PIPE_TAG_EN
  logic [TAG_W-1:0] s1_tag, s2_tag;
  always_ff @(posedge clk) begin
    if (in_xfer) s1_tag <= bus.in_tag;
    if (s1_valid && s2_en) s2_tag <= s1_tag;
    if (reset) bus.out_tag <= '0;
    else if (s2_valid && s3_en) bus.out_tag <= s2_tag;
  end
`endif
endmodule

// File: tb/tb_cpu_mult_pipe.sv
// tb_cpu_mult_pipe: directed self-checking bench for cpu_mult_pipe (32-bit unit plus a 64-bit unit)
module tb_cpu_mult_pipe;
  import cpu_mult_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  cpu_mult_pipe_if #(.DATA_W(32)) bus ();
`ifdef CPU_MULT_PIPE_TAG_EN
  cpu_mult_pipe_if #(.DATA_W(64), .TAG_W(5)) bus64 ();
`else
  cpu_mult_pipe_if #(.DATA_W(64)) bus64 ();
`endif
  cpu_mult_pipe #(.DATA_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  cpu_mult_pipe #(.DATA_W(64), .TAG_W(5)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

  function automatic logic [31:0] model_mul(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] ea, eb;
    logic signed [131:0] p;
    ea = {((m == 2'd1 || m == 2'd3) && a[31]) ? 34'h3_FFFF_FFFF : 34'h0, a};
    eb = {(m == 2'd1 && b[31]) ? 34'h3_FFFF_FFFF : 34'h0, b};
    p = ea * eb;
    return (m == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
    checks++; if (bus.out_result !== 32'h0) begin failures++; $display("FAIL reset_out_result got=%h want=0", bus.out_result); end
`ifdef CPU_MULT_PIPE_TAG_EN
    checks++; if (bus64.out_tag !== 5'h0) begin failures++; $display("FAIL reset_out_tag got=%h want=0", bus64.out_tag); end
`endif
  endtask

  task automatic test_modes;
    logic [31:0] exp_r [4];
    exp_r = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    bus.out_ready = 1'b1;
    bus.in_src1 = 32'hFFFF_FFFF;
    bus.in_src2 = 32'hFFFF_FFFF;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = c < 4;
      bus.in_mode = mode_e'(2'(c));
      #1;
      if (c < 4) begin
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL modes_in_ready c=%0d got=%0b want=1", c, bus.in_ready); end
      end
      if (c < 3 || c == 7) begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL modes_idle c=%0d out_valid got=%0b want=0", c, bus.out_valid); end
      end else begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== exp_r[c-3])
          begin failures++; $display("FAIL modes_result c=%0d got v=%0b r=%h want v=1 r=%h", c, bus.out_valid, bus.out_result, exp_r[c-3]); end
      end
      tick();
    end
  endtask

  task automatic test_minval;
    bus.out_ready = 1'b1;
    bus.in_src1 = 32'h8000_0000;
    bus.in_src2 = 32'h8000_0000;
    bus.in_valid = 1'b1;
    bus.in_mode = MULXSS;
    tick();
    bus.in_mode = MUL;
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h4000_0000)
      begin failures++; $display("FAIL minval_mulxss got v=%0b r=%h want v=1 r=40000000", bus.out_valid, bus.out_result); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0)
      begin failures++; $display("FAIL minval_mul got v=%0b r=%h want v=1 r=00000000", bus.out_valid, bus.out_result); end
    tick();
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode = MUL;
    bus.in_src2 = 32'd7;
    bus.in_src1 = 32'd100;
    tick();
    bus.in_src1 = 32'd101;
    tick();
    bus.in_src1 = 32'd102;
    tick();
    bus.in_src1 = 32'd103;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%0b want=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd700)
      begin failures++; $display("FAIL bp_first got v=%0b r=%0d want v=1 r=700", bus.out_valid, bus.out_result); end
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.out_result !== 32'd700)
      begin failures++; $display("FAIL bp_hold got rdy=%0b r=%0d want rdy=0 r=700", bus.in_ready, bus.out_result); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%0b want=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd707)
      begin failures++; $display("FAIL bp_second got v=%0b r=%0d want v=1 r=707", bus.out_valid, bus.out_result); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd714)
      begin failures++; $display("FAIL bp_third got v=%0b r=%0d want v=1 r=714", bus.out_valid, bus.out_result); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd721)
      begin failures++; $display("FAIL bp_fourth got v=%0b r=%0d want v=1 r=721", bus.out_valid, bus.out_result); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0b want=0", bus.out_valid); end
  endtask

  task automatic test_flush;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode = MUL;
    bus.in_src2 = 32'd3;
    bus.in_src1 = 32'd10;
    tick();
    bus.in_src1 = 32'd11;
    tick();
    bus.in_src1 = 32'd12;
    tick();
    bus.in_src1 = 32'd13;
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0b want=0", bus.in_ready); end
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_killed c=%0d out_valid got=%0b want=0", c, bus.out_valid); end
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_src1 = 32'd5;
    bus.in_src2 = 32'd6;
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_early got=%0b want=0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd30)
      begin failures++; $display("FAIL flush_after got v=%0b r=%0d want v=1 r=30", bus.out_valid, bus.out_result); end
    tick();
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_mode = MUL;
    bus.in_src2 = 32'd9;
    bus.in_src1 = 32'd2;
    tick();
    bus.in_src1 = 32'd3;
    tick();
    bus.in_src1 = 32'd4;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd18)
      begin failures++; $display("FAIL rstmid_pre got v=%0b r=%0d want v=1 r=18", bus.out_valid, bus.out_result); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 || bus.in_ready !== 1'b1)
      begin failures++; $display("FAIL rstmid_post got v=%0b r=%h rdy=%0b want v=0 r=0 rdy=1", bus.out_valid, bus.out_result, bus.in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_lost c=%0d out_valid got=%0b want=0", c, bus.out_valid); end
    end
  endtask

  task automatic test_stream;
    logic [31:0] a_v [8];
    logic [31:0] b_v [8];
    logic [1:0] m_v [8];
    logic [31:0] exp_q [$];
    logic [31:0] exp_r, prev_res;
    logic prev_stall;
    int sent, got, cyc;
    for (int i = 0; i < 8; i++) begin
      a_v[i] = $urandom;
      b_v[i] = $urandom;
      m_v[i] = 2'($urandom_range(0, 3));
    end
    sent = 0;
    got = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_res = '0;
    while (got < 8 && cyc < 200) begin
      bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      bus.in_valid = sent < 8;
      if (sent < 8) begin
        bus.in_src1 = a_v[sent];
        bus.in_src2 = b_v[sent];
        bus.in_mode = mode_e'(m_v[sent]);
      end
      #1;
      if (prev_stall) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== prev_res)
          begin failures++; $display("FAIL stream_hold cyc=%0d got v=%0b r=%h want v=1 r=%h", cyc, bus.out_valid, bus.out_result, prev_res); end
      end
      if (bus.out_valid && bus.out_ready) begin
        exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (bus.out_result !== exp_r)
          begin failures++; $display("FAIL stream_result n=%0d got=%h want=%h", got, bus.out_result, exp_r); end
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res = bus.out_result;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model_mul(m_v[sent], a_v[sent], b_v[sent]));
        sent++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got != 8) begin failures++; $display("FAIL stream_count got=%0d want=8", got); end
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_dup c=%0d out_valid got=%0b want=0", c, bus.out_valid); end
      tick();
    end
  endtask

  task automatic test_w64;
    bus64.out_ready = 1'b1;
    bus64.in_valid = 1'b1;
    bus64.in_mode = MULXSU;
    bus64.in_src1 = 64'hFFFF_FFFF_FFFF_FFFE;
    bus64.in_src2 = 64'd3;
`ifdef CPU_MULT_PIPE_TAG_EN
    bus64.in_tag = 5'h1A;
`endif
    tick();
    bus64.in_mode = MUL;
`ifdef CPU_MULT_PIPE_TAG_EN
    bus64.in_tag = 5'h05;
`endif
    tick();
    bus64.in_valid = 1'b0;
    tick();
    checks++; if (bus64.out_valid !== 1'b1 || bus64.out_result !== 64'hFFFF_FFFF_FFFF_FFFF)
      begin failures++; $display("FAIL w64_mulxsu got v=%0b r=%h want v=1 r=ffffffffffffffff", bus64.out_valid, bus64.out_result); end
`ifdef CPU_MULT_PIPE_TAG_EN
    checks++; if (bus64.out_tag !== 5'h1A) begin failures++; $display("FAIL w64_tag0 got=%h want=1a", bus64.out_tag); end
`endif
    tick();
    checks++; if (bus64.out_valid !== 1'b1 || bus64.out_result !== 64'hFFFF_FFFF_FFFF_FFFA)
      begin failures++; $display("FAIL w64_mul got v=%0b r=%h want v=1 r=fffffffffffffffa", bus64.out_valid, bus64.out_result); end
`ifdef CPU_MULT_PIPE_TAG_EN
    checks++; if (bus64.out_tag !== 5'h05) begin failures++; $display("FAIL w64_tag1 got=%h want=05", bus64.out_tag); end
`endif
    tick();
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_mode = MUL;
    bus.in_src1 = '0;
    bus.in_src2 = '0;
    bus.out_ready = 1'b1;
    bus64.flush = 1'b0;
    bus64.in_valid = 1'b0;
    bus64.in_mode = MUL;
    bus64.in_src1 = '0;
    bus64.in_src2 = '0;
    bus64.out_ready = 1'b1;
`ifdef CPU_MULT_PIPE_TAG_EN
    bus64.in_tag = '0;
`endif
    test_reset();
    test_modes();
    test_minval();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_stream();
    test_w64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cpu_mult_pipe.md
# cpu_mult_pipe

Parametrised, fully pipelined integer multiply unit for the CPU custom-datapath area. It computes the full 2×DATA_W product of two operands in one of four sign/half modes (low word, high signed×signed, high unsigned×unsigned, high signed×unsigned). It replaces fixed-width, fixed-latency multiply cells with a valid/ready-handshaked three-stage pipeline that sustains one operation per cycle, supports back-pressure and offers a flush. It sits between the execute-stage operand mux and the writeback mux.

## Interface
- DATA_W, 32: operand/result width; multiple of 16, legal range 16..64
- TAG_W, 5: width of the tag carried alongside each operation; only used with CPU_MULT_PIPE_TAG_EN
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  kills all in-flight operations this cycle
- in_valid  in  1  operands presented
- in_ready  out  1  pipeline can accept this cycle
- in_mode  in  2  0=MUL (low word), 1=MULXSS, 2=MULXUU, 3=MULXSU (src1 signed, src2 unsigned)
- in_src1  in  DATA_W  operand A
- in_src2  in  DATA_W  operand B
- in_tag  in  TAG_W  tag, present only with CPU_MULT_PIPE_TAG_EN
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  DATA_W  selected product word
- out_tag  out  TAG_W  tag of out_result, present only with CPU_MULT_PIPE_TAG_EN

## Operation
- Stage S1: register operands, mode and tag; sign-extend each operand to DATA_W+1 bits per mode (MUL treated as unsigned; the low word is identical for all modes).
- Stage S2: split extended operands into N=DATA_W/16 chunks; compute the N×N chunk partial products (top chunk signed 17-bit, others unsigned zero-extended to 17-bit), registered.
- Stage S3: shift-sum the partial products into a 2×DATA_W product; register low word for MUL, high word otherwise.
- Each stage holds a valid bit. Stage k advances when stage k+1 is empty or advancing; S3 advances when !out_valid || out_ready.
- in_ready = !s1_valid || s1_advance. Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
- Stalled stages hold data stable; out_result/out_tag must not change while out_valid && !out_ready.
- flush: clears all valid bits next cycle; an in_valid && in_ready in the same cycle is discarded; in_ready is forced 0 during flush.
- reset mid-operation: same as flush; all in-flight data is lost and no out_valid follows.
- Data registers are not reset (valid bits only); out_result must read 0 after reset until the first result (gate or reset the S3 register).
- Arithmetic is modulo 2^(2×DATA_W); no overflow flag.

## Timing
- Reset values: in_ready=1 (cycle after reset deasserts), out_valid=0, out_result=0, out_tag=0.
- Latency: an operation accepted at edge t presents out_valid at edge t+3 with no stall.
- Throughput: one op per cycle with out_ready held high; a bubble-free stream of M ops completes in M+3 cycles.
- Stall: out_ready low fills S3, S2, S1 in successive cycles; in_ready drops combinationally once S1 is full and blocked. in_ready depends combinationally on out_ready (no skid buffer).
- Simultaneous transfer in and out with all stages full is legal; the pipeline stays full.

## Configuration
- CPU_MULT_PIPE_TAG_EN defined: in_tag/out_tag ports exist; the tag travels with its operation through all stages and is stalled and flushed identically.
- Undefined: tag ports, tag registers and TAG_W usage are absent; all other behaviour is identical.

## Structure
- Shared package cpu_mult_pkg: mode enum (MUL, MULXSS, MULXUU, MULXSU), CHUNK_W=16 constant, helper function for chunk count.
- Sub-module cpu_mult_pipe_cell: one registered 17×17 signed multiply with enable; instantiated N×N times in S2.
- Elaboration-time check: DATA_W%16==0 and 16≤DATA_W≤64, else error.

## Test plan
- DATA_W=32, src1=src2=0xFFFFFFFF, modes 0..3 back-to-back -> results 0x00000001, 0x00000000, 0xFFFFFFFE, 0xFFFFFFFF on consecutive cycles, first at accept+3.
- src1=src2=0x80000000 mode MULXSS -> 0x40000000; mode MUL -> 0x00000000.
- Stream 8 random ops, out_ready toggling 1-0-0-1 pattern -> all 8 results in order, matching the reference model, values held during stall, no loss or duplicate.
- flush asserted with 3 ops in flight plus one presented -> no out_valid for any of the 4; next accepted op returns correctly at +3.
- reset asserted for 1 cycle mid-stream -> out_valid=0, out_result=0 next cycle; in_ready=1 afterwards.
- DATA_W=64 with TAG_EN, src1=-2 (mode MULXSU), src2=3, tag 0x1A -> high word 0xFFFFFFFFFFFFFFFF, out_tag=0x1A.
